// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: instruction-type opcodes, funct3 access encodings,
// LSU exception codes and the LSU FSM state encoding.
package riscv_pkg;

    localparam logic [6:0] IS_LOAD  = 7'b0000011;
    localparam logic [6:0] IS_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size lives in funct3[1:0] for both loads and stores.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [1:0] EXC_NONE       = 2'b00;
    localparam logic [1:0] EXC_MISALIGNED = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT    = 2'b10;
    localparam logic [1:0] EXC_ILLEGAL    = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_e;

    function automatic logic load_f3_legal(input logic [2:0] f3);
        return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    endfunction

    function automatic logic store_f3_legal(input logic [2:0] f3);
        return f3 inside {F3_SB, F3_SH, F3_SW};
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Load-data lane selection and sign/zero extension for the LSU writeback path.
module riscv_lsu_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: single outstanding memory request with legality and alignment
// checks, ack timeout, and a registered writeback/exception port.
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_load,
    input  logic                 in_store,
    input  logic [2:0]           in_funct3,
    input  logic [BUS_WIDTH-1:0] in_addr,
    input  logic [BUS_WIDTH-1:0] in_wdata,
    input  logic [4:0]           in_rd,
    input  logic                 in_rde,
    output logic                 stall,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [BUS_WIDTH-1:0] mem_addr,
    output logic [3:0]           mem_be,
    output logic [BUS_WIDTH-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [BUS_WIDTH-1:0] mem_rdata,
    output logic                 wb_valid,
    output logic [4:0]           wb_rd,
    output logic [BUS_WIDTH-1:0] wb_data,
    output logic                 exc_valid,
    output logic [1:0]           exc_code,
    output logic [BUS_WIDTH-1:0] exc_addr
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    lsu_state_e           state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [BUS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]           mem_be_q, mem_be_d;
    logic [BUS_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [4:0]           wb_rd_q, wb_rd_d;
    logic [BUS_WIDTH-1:0] wb_data_q, wb_data_d;
    logic                 exc_valid_q, exc_valid_d;
    logic [1:0]           exc_code_q, exc_code_d;
    logic [BUS_WIDTH-1:0] exc_addr_q, exc_addr_d;
    logic [2:0]           pend_funct3_q, pend_funct3_d;
    logic [1:0]           pend_off_q, pend_off_d;
    logic [4:0]           pend_rd_q, pend_rd_d;
    logic                 pend_rde_q, pend_rde_d;
    logic [BUS_WIDTH-1:0] req_addr_q, req_addr_d;

    logic                 is_mem;
    logic                 legal;
    logic                 misaligned;
    logic [3:0]           be;
    logic [BUS_WIDTH-1:0] wdata_rep;
    logic [7:0]           cnt_inc;
    logic [BUS_WIDTH-1:0] load_data;

    riscv_lsu_align u_align (
        .rdata  (mem_rdata),
        .offset (pend_off_q),
        .funct3 (pend_funct3_q),
        .data   (load_data)
    );

    // Request decode for the op currently presented by execute; loads win if both flags are set.
    always_comb begin
        is_mem     = in_load | in_store;
        legal      = in_load ? load_f3_legal(in_funct3) : store_f3_legal(in_funct3);
        misaligned = ((in_funct3[1:0] == SIZE_HALF) && in_addr[0]) ||
                     ((in_funct3[1:0] == SIZE_WORD) && (in_addr[1:0] != 2'b00));
        case (in_funct3[1:0])
            SIZE_BYTE: begin
                be        = 4'b0001 << in_addr[1:0];
                wdata_rep = {4{in_wdata[7:0]}};
            end
            SIZE_HALF: begin
                be        = in_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{in_wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = in_wdata;
            end
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_be_d      = mem_be_q;
        mem_wdata_d   = mem_wdata_q;
        wb_valid_d    = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;
        exc_valid_d   = 1'b0;
        exc_code_d    = exc_code_q;
        exc_addr_d    = exc_addr_q;
        pend_funct3_d = pend_funct3_q;
        pend_off_d    = pend_off_q;
        pend_rd_d     = pend_rd_q;
        pend_rde_d    = pend_rde_q;
        req_addr_d    = req_addr_q;
        cnt_inc       = cnt_q + 8'd1;

        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (in_valid) begin
                    if (!is_mem) begin
                        wb_valid_d = in_rde && (in_rd != 5'd0);
                        wb_rd_d    = in_rd;
                        wb_data_d  = in_addr;
                    end else if (!legal) begin
                        exc_valid_d = 1'b1;
                        exc_code_d  = EXC_ILLEGAL;
                        exc_addr_d  = in_addr;
                    end else if (misaligned) begin
                        exc_valid_d = 1'b1;
                        exc_code_d  = EXC_MISALIGNED;
                        exc_addr_d  = in_addr;
                    end else begin
                        state_d       = WAIT;
                        mem_req_d     = 1'b1;
                        mem_we_d      = !in_load;
                        mem_addr_d    = {in_addr[BUS_WIDTH-1:2], 2'b00};
                        mem_be_d      = be;
                        mem_wdata_d   = wdata_rep;
                        pend_funct3_d = in_funct3;
                        pend_off_d    = in_addr[1:0];
                        pend_rd_d     = in_rd;
                        pend_rde_d    = in_rde;
                        req_addr_d    = in_addr;
                    end
                end
            end
            WAIT: begin
                // An ack on the final permitted cycle still completes normally.
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    cnt_d     = 8'd0;
                    if (!mem_we_q) begin
                        wb_valid_d = pend_rde_q && (pend_rd_q != 5'd0);
                        wb_rd_d    = pend_rd_q;
                        wb_data_d  = load_data;
                    end
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    cnt_d       = 8'd0;
                    exc_valid_d = 1'b1;
                    exc_code_d  = EXC_TIMEOUT;
                    exc_addr_d  = req_addr_q;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_be_q      <= '0;
            mem_wdata_q   <= '0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            exc_valid_q   <= 1'b0;
            exc_code_q    <= EXC_NONE;
            exc_addr_q    <= '0;
            pend_funct3_q <= '0;
            pend_off_q    <= '0;
            pend_rd_q     <= '0;
            pend_rde_q    <= 1'b0;
            req_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_be_q      <= mem_be_d;
            mem_wdata_q   <= mem_wdata_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            exc_valid_q   <= exc_valid_d;
            exc_code_q    <= exc_code_d;
            exc_addr_q    <= exc_addr_d;
            pend_funct3_q <= pend_funct3_d;
            pend_off_q    <= pend_off_d;
            pend_rd_q     <= pend_rd_d;
            pend_rde_q    <= pend_rde_d;
            req_addr_q    <= req_addr_d;
        end
    end

    assign stall     = (state_q == WAIT);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign exc_valid = exc_valid_q;
    assign exc_code  = exc_code_q;
    assign exc_addr  = exc_addr_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Testbench for riscv_lsu: directed vector table, mid-transaction reset sequence,
// and randomized ops checked against a behavioural model of the LSU rules.
module tb_riscv_lsu;

    localparam int TIMEOUT = 4;

    typedef struct {
        logic        isLoad;
        logic        isStore;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        rde;
    } op_t;

    typedef struct {
        int          reqCycles;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stallCycles;
        int          wbCount;
        logic [4:0]  wbRd;
        logic [31:0] wbData;
        int          excCount;
        logic [1:0]  excCode;
        logic [31:0] excAddr;
        int          unstable;
        int          overlap;
    } obs_t;

    typedef struct {
        op_t         op;
        int          ackDelay;
        logic [31:0] rdata;
        obs_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid, inLoad, inStore, inRde;
    logic [2:0]  inFunct3;
    logic [31:0] inAddr, inWdata;
    logic [4:0]  inRd;
    logic        memAck;
    logic [31:0] memRdata;
    logic        stall, memReq, memWe, wbValid, excValid;
    logic [31:0] memAddr, memWdata, wbData, excAddr;
    logic [3:0]  memBe;
    logic [4:0]  wbRd;
    logic [1:0]  excCode;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [2:0] loadF3 [5]  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0] storeF3 [3] = '{3'd0, 3'd1, 3'd2};
    vec_t vecs [18];

    riscv_lsu #(.BUS_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inValid),
        .in_load   (inLoad),
        .in_store  (inStore),
        .in_funct3 (inFunct3),
        .in_addr   (inAddr),
        .in_wdata  (inWdata),
        .in_rd     (inRd),
        .in_rde    (inRde),
        .stall     (stall),
        .mem_req   (memReq),
        .mem_we    (memWe),
        .mem_addr  (memAddr),
        .mem_be    (memBe),
        .mem_wdata (memWdata),
        .mem_ack   (memAck),
        .mem_rdata (memRdata),
        .wb_valid  (wbValid),
        .wb_rd     (wbRd),
        .wb_data   (wbData),
        .exc_valid (excValid),
        .exc_code  (excCode),
        .exc_addr  (excAddr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic obs_t emptyObs();
        obs_t o;
        o.reqCycles = 0;   o.we = 1'b0;     o.be = '0;      o.addr = '0;
        o.wdata = '0;      o.stallCycles = 0; o.wbCount = 0; o.wbRd = '0;
        o.wbData = '0;     o.excCount = 0;  o.excCode = '0; o.excAddr = '0;
        o.unstable = 0;    o.overlap = 0;
        return o;
    endfunction

    // Behavioural model: what one op should produce, from the architectural rules.
    function automatic obs_t model(input op_t op, input int ackDelay, input logic [31:0] rdata);
        obs_t        e;
        int          nb;
        int          off;
        logic        legal;
        logic [31:0] shifted;
        logic [31:0] mask;
        logic [31:0] val;
        e   = emptyObs();
        nb  = 1 << op.funct3[1:0];
        off = int'(op.addr % 32'd4);
        if (!op.isLoad && !op.isStore) begin
            if (op.rde && op.rd != 5'd0) begin
                e.wbCount = 1;
                e.wbRd    = op.rd;
                e.wbData  = op.addr;
            end
            return e;
        end
        legal = op.isLoad ? (op.funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                          : (op.funct3 inside {3'd0, 3'd1, 3'd2});
        if (!legal || (op.addr % 32'(nb)) != 32'd0) begin
            e.excCount = 1;
            e.excCode  = legal ? 2'b01 : 2'b11;
            e.excAddr  = op.addr;
            return e;
        end
        e.we   = op.isStore;
        e.addr = op.addr - 32'(off);
        e.be   = 4'(((1 << nb) - 1) << off);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = op.wdata[8*(i % nb) +: 8];
        if (ackDelay >= 0 && ackDelay < TIMEOUT) begin
            e.stallCycles = ackDelay + 1;
            e.reqCycles   = e.stallCycles;
            if (op.isLoad && op.rde && op.rd != 5'd0) begin
                shifted = rdata >> (8 * off);
                if (nb == 4) begin
                    val = rdata;
                end else begin
                    mask = (32'd1 << (8 * nb)) - 32'd1;
                    val  = shifted & mask;
                    if (!op.funct3[2] && shifted[8*nb-1]) val = val | ~mask;
                end
                e.wbCount = 1;
                e.wbRd    = op.rd;
                e.wbData  = val;
            end
        end else begin
            e.stallCycles = TIMEOUT;
            e.reqCycles   = TIMEOUT;
            e.excCount    = 1;
            e.excCode     = 2'b10;
            e.excAddr     = op.addr;
        end
        return e;
    endfunction

    function automatic vec_t mkVec(input logic ld, st, input logic [2:0] f3,
                                   input logic [31:0] addr, wdata, input logic [4:0] rd,
                                   input logic rde, input int ackDelay, input logic [31:0] rdata,
                                   input int stallCyc, input logic [3:0] be,
                                   input logic [31:0] mwdata, input int wbCnt,
                                   input logic [31:0] wbVal, input logic [1:0] code);
        vec_t v;
        v.op          = '{isLoad: ld, isStore: st, funct3: f3, addr: addr, wdata: wdata, rd: rd, rde: rde};
        v.ackDelay    = ackDelay;
        v.rdata       = rdata;
        v.exp         = emptyObs();
        v.exp.stallCycles = stallCyc;
        v.exp.reqCycles   = stallCyc;
        v.exp.we      = st;
        v.exp.be      = be;
        v.exp.addr    = {addr[31:2], 2'b00};
        v.exp.wdata   = mwdata;
        v.exp.wbCount = wbCnt;
        v.exp.wbRd    = rd;
        v.exp.wbData  = wbVal;
        v.exp.excCount = (code != 2'b00) ? 1 : 0;
        v.exp.excCode = code;
        v.exp.excAddr = addr;
        return v;
    endfunction

    // Presents one op, plays the memory side, and records everything until two idle cycles.
    task automatic applyStimulus(input op_t op, input int ackDelay, input logic [31:0] rdata, output obs_t ob);
        int   quiet;
        logic captured;
        ob       = emptyObs();
        quiet    = 0;
        captured = 1'b0;
        inValid  = 1'b1;
        inLoad   = op.isLoad;
        inStore  = op.isStore;
        inFunct3 = op.funct3;
        inAddr   = op.addr;
        inWdata  = op.wdata;
        inRd     = op.rd;
        inRde    = op.rde;
        memRdata = rdata;
        memAck   = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 40 && quiet < 2; cyc++) begin
            @(posedge clk);
            #1;
            if (wbValid) begin
                ob.wbCount++;
                ob.wbRd   = wbRd;
                ob.wbData = wbData;
            end
            if (excValid) begin
                ob.excCount++;
                ob.excCode = excCode;
                ob.excAddr = excAddr;
            end
            if (wbValid && excValid) ob.overlap++;
            if (memReq) begin
                if (captured && (memWe !== ob.we || memBe !== ob.be ||
                                 memAddr !== ob.addr || memWdata !== ob.wdata))
                    ob.unstable++;
                ob.reqCycles++;
                ob.we    = memWe;
                ob.be    = memBe;
                ob.addr  = memAddr;
                ob.wdata = memWdata;
                captured = 1'b1;
            end
            if (stall) begin
                ob.stallCycles++;
                memAck = (ackDelay >= 0) && (ob.stallCycles == ackDelay + 1);
            end else begin
                quiet++;
                inValid = 1'b0;
                memAck  = 1'($urandom_range(0, 1));
            end
        end
        inValid = 1'b0;
        memAck  = 1'b0;
    endtask

    task automatic checkObs(input string tag, input obs_t got, input obs_t exp);
        checkOutput({tag, " stallCycles"}, 32'(got.stallCycles), 32'(exp.stallCycles));
        checkOutput({tag, " reqCycles"}, 32'(got.reqCycles), 32'(exp.reqCycles));
        checkOutput({tag, " wbCount"}, 32'(got.wbCount), 32'(exp.wbCount));
        checkOutput({tag, " excCount"}, 32'(got.excCount), 32'(exp.excCount));
        checkOutput({tag, " wbExcOverlap"}, 32'(got.overlap), 32'd0);
        checkOutput({tag, " reqUnstable"}, 32'(got.unstable), 32'd0);
        if (exp.reqCycles > 0) begin
            checkOutput({tag, " memWe"}, 32'(got.we), 32'(exp.we));
            checkOutput({tag, " memBe"}, 32'(got.be), 32'(exp.be));
            checkOutput({tag, " memAddr"}, got.addr, exp.addr);
            if (exp.we) checkOutput({tag, " memWdata"}, got.wdata, exp.wdata);
        end
        if (exp.wbCount > 0) begin
            checkOutput({tag, " wbRd"}, 32'(got.wbRd), 32'(exp.wbRd));
            checkOutput({tag, " wbData"}, got.wbData, exp.wbData);
        end
        if (exp.excCount > 0) begin
            checkOutput({tag, " excCode"}, 32'(got.excCode), 32'(exp.excCode));
            checkOutput({tag, " excAddr"}, got.excAddr, exp.excAddr);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " stall"}, 32'(stall), 32'd0);
        checkOutput({tag, " memReq"}, 32'(memReq), 32'd0);
        checkOutput({tag, " memWe"}, 32'(memWe), 32'd0);
        checkOutput({tag, " memAddr"}, memAddr, 32'd0);
        checkOutput({tag, " memBe"}, 32'(memBe), 32'd0);
        checkOutput({tag, " memWdata"}, memWdata, 32'd0);
        checkOutput({tag, " wbValid"}, 32'(wbValid), 32'd0);
        checkOutput({tag, " wbRd"}, 32'(wbRd), 32'd0);
        checkOutput({tag, " wbData"}, wbData, 32'd0);
        checkOutput({tag, " excValid"}, 32'(excValid), 32'd0);
        checkOutput({tag, " excCode"}, 32'(excCode), 32'd0);
        checkOutput({tag, " excAddr"}, excAddr, 32'd0);
    endtask

    initial begin
        obs_t        got;
        op_t         op;
        int          ackDelay;
        int          kind;
        int          idleWb, idleExc, idleReq, idleStall;

        // ld, st, f3, addr, wdata, rd, rde, ackDelay, rdata, stall, be, memWdata, wbCount, wbData, excCode
        vecs[0]  = mkVec(1, 0, 3'b010, 32'h100, 32'h0, 5'd5, 1, 3, 32'hDEADBEEF, 4, 4'b1111, 32'h0, 1, 32'hDEADBEEF, 2'b00);
        vecs[1]  = mkVec(1, 0, 3'b000, 32'h103, 32'h0, 5'd7, 1, 0, 32'h80FFFFFF, 1, 4'b1000, 32'h0, 1, 32'hFFFFFF80, 2'b00);
        vecs[2]  = mkVec(1, 0, 3'b100, 32'h103, 32'h0, 5'd7, 1, 0, 32'h80FFFFFF, 1, 4'b1000, 32'h0, 1, 32'h00000080, 2'b00);
        vecs[3]  = mkVec(0, 1, 3'b001, 32'h0E, 32'h1234ABCD, 5'd2, 1, 1, 32'h0, 2, 4'b1100, 32'hABCDABCD, 0, 32'h0, 2'b00);
        vecs[4]  = mkVec(1, 0, 3'b010, 32'h102, 32'h0, 5'd6, 1, 0, 32'h0, 0, 4'b0000, 32'h0, 0, 32'h0, 2'b01);
        vecs[5]  = mkVec(1, 0, 3'b011, 32'h102, 32'h0, 5'd6, 1, 0, 32'h0, 0, 4'b0000, 32'h0, 0, 32'h0, 2'b11);
        vecs[6]  = mkVec(1, 0, 3'b010, 32'h40, 32'h0, 5'd8, 1, -1, 32'h0, 4, 4'b1111, 32'h0, 0, 32'h0, 2'b10);
        vecs[7]  = mkVec(0, 0, 3'b000, 32'h42, 32'h0, 5'd3, 1, -1, 32'h0, 0, 4'b0000, 32'h0, 1, 32'h42, 2'b00);
        vecs[8]  = mkVec(0, 0, 3'b000, 32'h99, 32'h0, 5'd0, 1, -1, 32'h0, 0, 4'b0000, 32'h0, 0, 32'h0, 2'b00);
        vecs[9]  = mkVec(1, 0, 3'b001, 32'h06, 32'h0, 5'd10, 1, 2, 32'h80017FFF, 3, 4'b1100, 32'h0, 1, 32'hFFFF8001, 2'b00);
        vecs[10] = mkVec(1, 0, 3'b101, 32'h06, 32'h0, 5'd10, 1, 2, 32'h80017FFF, 3, 4'b1100, 32'h0, 1, 32'h00008001, 2'b00);
        vecs[11] = mkVec(0, 1, 3'b000, 32'h21, 32'h000000A5, 5'd1, 1, 0, 32'h0, 1, 4'b0010, 32'hA5A5A5A5, 0, 32'h0, 2'b00);
        vecs[12] = mkVec(0, 1, 3'b110, 32'h33, 32'h11223344, 5'd1, 1, 0, 32'h0, 0, 4'b0000, 32'h0, 0, 32'h0, 2'b11);
        vecs[13] = mkVec(1, 0, 3'b001, 32'h01, 32'h0, 5'd12, 1, 0, 32'h0, 0, 4'b0000, 32'h0, 0, 32'h0, 2'b01);
        vecs[14] = mkVec(1, 0, 3'b010, 32'h60, 32'h0, 5'd0, 1, 0, 32'h12345678, 1, 4'b1111, 32'h0, 0, 32'h0, 2'b00);
        vecs[15] = mkVec(1, 0, 3'b000, 32'h22, 32'h0, 5'd9, 0, 1, 32'h12345678, 2, 4'b0100, 32'h0, 0, 32'h0, 2'b00);
        vecs[16] = mkVec(0, 1, 3'b010, 32'h34, 32'hCAFEF00D, 5'd1, 1, 4, 32'h0, 4, 4'b1111, 32'hCAFEF00D, 0, 32'h0, 2'b10);
        vecs[17] = mkVec(1, 0, 3'b000, 32'h101, 32'h0, 5'd11, 1, 0, 32'h12347F56, 1, 4'b0010, 32'h0, 1, 32'h0000007F, 2'b00);

        reset    = 1'b1;
        inValid  = 1'b0;
        inLoad   = 1'b0;
        inStore  = 1'b0;
        inFunct3 = 3'd0;
        inAddr   = 32'h0;
        inWdata  = 32'h0;
        inRd     = 5'd0;
        inRde    = 1'b0;
        memAck   = 1'b0;
        memRdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checkResetState("initReset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].op, vecs[i].ackDelay, vecs[i].rdata, got);
            checkObs($sformatf("vec%0d", i), got, vecs[i].exp);
        end

        // Reset lands during the second WAIT cycle of a load; a late ack must be ignored.
        inValid  = 1'b1;
        inLoad   = 1'b1;
        inStore  = 1'b0;
        inFunct3 = 3'b010;
        inAddr   = 32'h80;
        inRd     = 5'd4;
        inRde    = 1'b1;
        memAck   = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midReset stallWait1", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("midReset stallWait2", 32'(stall), 32'd1);
        reset   = 1'b1;
        inValid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkResetState("midReset");
        memAck    = 1'b1;
        memRdata  = 32'h5555AAAA;
        idleWb    = 0;
        idleExc   = 0;
        idleReq   = 0;
        idleStall = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            memAck = 1'b0;
            if (wbValid) idleWb++;
            if (excValid) idleExc++;
            if (memReq) idleReq++;
            if (stall) idleStall++;
        end
        checkOutput("midReset lateAck wbValid", 32'(idleWb), 32'd0);
        checkOutput("midReset lateAck excValid", 32'(idleExc), 32'd0);
        checkOutput("midReset lateAck memReq", 32'(idleReq), 32'd0);
        checkOutput("midReset lateAck stall", 32'(idleStall), 32'd0);
        op = '{isLoad: 1'b0, isStore: 1'b0, funct3: 3'd0, addr: 32'h42, wdata: 32'h0, rd: 5'd3, rde: 1'b1};
        applyStimulus(op, -1, 32'h0, got);
        checkObs("postReset alu", got, model(op, -1, 32'h0));

        for (int n = 0; n < 200; n++) begin
            kind       = int'($urandom_range(0, 2));
            op.isLoad  = (kind == 1);
            op.isStore = (kind == 2);
            op.funct3  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                if (op.isLoad) op.funct3 = loadF3[$urandom_range(0, 4)];
                else           op.funct3 = storeF3[$urandom_range(0, 2)];
            end
            op.addr  = $urandom;
            if ($urandom_range(0, 1) == 1) op.addr[1:0] = 2'b00;
            op.wdata = $urandom;
            op.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            op.rde   = ($urandom_range(0, 5) != 0);
            ackDelay = int'($urandom_range(0, 6)) - 1;
            memRdata = $urandom;
            applyStimulus(op, ackDelay, memRdata, got);
            checkObs($sformatf("rand%0d", n), got, model(op, ackDelay, memRdata));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, meaning the data/address width; only 32 is supported.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles to wait for mem_ack; range 1..255.
REQ-003 SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-004 SHALL have ports, listed as name / direction / width / meaning:
- clk / in / 1 / clock, rising edge.
- reset / in / 1 / synchronous, active-high.
- in_valid / in / 1 / an execute-stage result is present.
- in_load / in / 1 / the op is a load.
- in_store / in / 1 / the op is a store.
- in_funct3 / in / 3 / access size and signedness.
- in_addr / in / 32 / effective address, or the ALU result for non-memory ops.
- in_wdata / in / 32 / store data (rs2).
- in_rd / in / 5 / destination register.
- in_rde / in / 1 / destination-write enable.
- stall / out / 1 / upstream must hold its inputs.
- mem_req / out / 1 / memory request.
- mem_we / out / 1 / 1 = store.
- mem_addr / out / 32 / word-aligned address, addr[1:0] = 0.
- mem_be / out / 4 / byte lane enables.
- mem_wdata / out / 32 / lane-replicated store data.
- mem_ack / in / 1 / request completed.
- mem_rdata / in / 32 / read word, valid when mem_ack = 1.
- wb_valid / out / 1 / writeback strobe.
- wb_rd / out / 5 / writeback register.
- wb_data / out / 32 / writeback value.
- exc_valid / out / 1 / one-cycle exception pulse.
- exc_code / out / 2 / 01 = misaligned, 10 = bus timeout, 11 = illegal funct3.
- exc_addr / out / 32 / faulting in_addr.

Function
REQ-005 SHALL implement FSM states IDLE and WAIT; stall = (state == WAIT).
REQ-006 SHALL, in IDLE with in_valid and neither load nor store: wb_valid = in_rde & (in_rd != 0), wb_rd = in_rd, wb_data = in_addr, all registered (1-cycle latency).
REQ-007 SHALL, in IDLE with in_valid and a load or store: check legality; legal load funct3 = 000, 001, 010, 100, 101; legal store funct3 = 000, 001, 010.
REQ-008 SHALL flag an access as misaligned when it is a halfword with addr[0] = 1, or a word with addr[1:0] != 0.
REQ-009 SHALL, on an illegal or misaligned access: pulse exc_valid next cycle with exc_addr = in_addr, issue no mem_req, produce no writeback, and remain in IDLE. Illegal funct3 takes priority over misaligned.
REQ-010 SHALL, on a legal access: register the request and enter WAIT. mem_req = 1 from the next cycle and is held, with addr/be/wdata stable, until mem_ack is sampled high.
REQ-011 SHALL generate byte enables as follows: byte = 0001 << addr[1:0]; half = 0011 or 1100 by addr[1]; word = 1111. Store data SHALL be replicated across lanes (byte ×4, half ×2).
REQ-012 SHALL, on mem_ack in WAIT: return to IDLE; mem_req drops the following cycle.
REQ-013 SHALL, for a load, assert wb_valid on the cycle after mem_ack, with the selected lane sign-extended for funct3 000/001 and zero-extended for 100/101.
REQ-014 SHALL never assert wb_valid when rd == 0.
REQ-015 SHALL treat stores as complete at mem_ack, with no writeback.
REQ-016 SHALL count WAIT cycles with an 8-bit counter. When the counter reaches TIMEOUT without mem_ack: pulse exc_valid with code 10, drop mem_req, return to IDLE, and produce no writeback.
REQ-017 SHALL let mem_ack win if it arrives on the same cycle the timeout is reached.
REQ-018 SHALL ignore in_valid while in WAIT; upstream holds its inputs under stall.
REQ-019 SHALL ignore mem_ack while in IDLE.
REQ-020 SHALL assert wb_valid and exc_valid for exactly one cycle per event, and never both in the same cycle.

Reset
REQ-021 SHALL, when reset is asserted, set the following to 0 at the next edge: state = IDLE, mem_req, mem_we, mem_be, mem_addr, mem_wdata, wb_valid, wb_rd, wb_data, exc_valid, exc_code, exc_addr, and the timeout counter.
REQ-022 SHALL, on reset mid-WAIT, abandon the transaction with no writeback and no exception, and ignore any later mem_ack.

Structure
REQ-023 SHALL take funct3 encodings, exc_code values and FSM state encodings from the shared riscv_pkg package, next to the existing IS_LOAD/IS_STORE instruction-type defines.
REQ-024 SHALL place the load-data alignment and extension logic in one combinational sub-module, riscv_lsu_align.

Verification
REQ-025 LW at addr 0x100, mem_rdata 0xDEADBEEF, ack after 3 wait cycles, rd = 5 -> mem_be = 1111, stall high for 4 cycles, wb_data = 0xDEADBEEF to rd 5.
REQ-026 LB at 0x103, mem_rdata 0x80FFFFFF -> mem_be = 1000, wb_data = 0xFFFFFF80; the same access as LBU -> 0x00000080.
REQ-027 SH at 0x0E, in_wdata 0x1234ABCD -> mem_be = 1100, mem_wdata = 0xABCDABCD, mem_we = 1, no wb_valid.
REQ-028 LW at 0x102 -> exc_valid with code 01 and exc_addr = 0x102, mem_req never asserted; then funct3 = 011 load -> code 11.
REQ-029 Load with mem_ack never asserted and TIMEOUT = 4 -> exc code 10 after 4 WAIT cycles, mem_req deasserted, stall low.
REQ-030 Reset asserted on the 2nd WAIT cycle, then mem_ack pulsed -> no wb_valid or exc_valid; a later ALU op (in_addr 0x42, rd 3) -> wb_data = 0x42 after 1 cycle.
